// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: requester, core and result signals of the shared multiplier arbiter.
// req_lock exists only when MUL_ARB_LOCK_EN is defined.
interface booth_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW = 16
);
  logic flush;
  logic [N_REQ-1:0] req_vld;
  logic [N_REQ-1:0] req_rdy;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
`ifdef MUL_ARB_LOCK_EN
  logic [N_REQ-1:0] req_lock;
`endif
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic mul_vld;
  logic [2*DW-1:0] mul_p;
  logic [2*DW-1:0] res_p;
  logic [N_REQ-1:0] res_vld;
  logic busy;
`ifdef MUL_ARB_LOCK_EN
  modport master (output flush, req_vld, req_a, req_b, req_lock, mul_p,
                  input req_rdy, mul_a, mul_b, mul_vld, res_p, res_vld, busy);
  modport slave (input flush, req_vld, req_a, req_b, req_lock, mul_p,
                 output req_rdy, mul_a, mul_b, mul_vld, res_p, res_vld, busy);
`else
  modport master (output flush, req_vld, req_a, req_b, mul_p,
                  input req_rdy, mul_a, mul_b, mul_vld, res_p, res_vld, busy);
  modport slave (input flush, req_vld, req_a, req_b, mul_p,
                 output req_rdy, mul_a, mul_b, mul_vld, res_p, res_vld, busy);
`endif
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin issue of N_REQ operand streams into one pipelined signed multiplier,
// with a tag pipe routing each product back to its requester. Define MUL_ARB_LOCK_EN for burst lock.
module booth_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW = 16,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst_n,
  booth_mul_arbiter_if.slave bus
);
  localparam logic [N_REQ-1:0] lsb = 1;
  logic [2:0] ptr, gi, nxt_ptr;
  logic [N_REQ-1:0] gnt, res_vld;
  logic [DW-1:0] sel_a, sel_b, mul_a, mul_b;
  logic [2*DW-1:0] res_p;
  logic [MUL_LAT:0] tv;
  logic [2:0] ti [MUL_LAT+1];
  logic fire;
`ifdef MUL_ARB_LOCK_EN
  logic lock;
`endif
  function automatic int slot(input logic [2:0] p, input int k);
    return (int'(p) + k) % N_REQ;
  endfunction
  always_comb begin
    gnt = '0;
    gi = '0;
    sel_a = '0;
    sel_b = '0;
`ifdef MUL_ARB_LOCK_EN
    lock = 1'b0;
`endif
    for (int k = 0; k < N_REQ; k++)
      if (gnt == '0 && bus.req_vld[slot(ptr, k)]) begin
        gnt[slot(ptr, k)] = 1'b1;
        gi = 3'(slot(ptr, k));
        sel_a = bus.req_a[slot(ptr, k)*DW +: DW];
        sel_b = bus.req_b[slot(ptr, k)*DW +: DW];
`ifdef MUL_ARB_LOCK_EN
        lock = bus.req_lock[slot(ptr, k)];
`endif
      end
    if (bus.flush || !rst_n) gnt = '0;
  end
  assign fire = |gnt;
  // A locked transfer keeps the grantee at the head of the search order.
`ifdef MUL_ARB_LOCK_EN
  assign nxt_ptr = lock ? gi : (gi == 3'(N_REQ-1) ? 3'd0 : gi + 3'd1);
`else
  assign nxt_ptr = gi == 3'(N_REQ-1) ? 3'd0 : gi + 3'd1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      tv <= '0;
      for (int k = 0; k <= MUL_LAT; k++) ti[k] <= '0;
      mul_a <= '0;
      mul_b <= '0;
      res_p <= '0;
      res_vld <= '0;
    end else begin
      if (fire) begin
        ptr <= nxt_ptr;
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      tv <= bus.flush ? '0 : {tv[MUL_LAT-1:0], fire};
      ti[0] <= gi;
      for (int k = 1; k <= MUL_LAT; k++) ti[k] <= ti[k-1];
      // Last tag stage lines up with mul_p; a flush suppresses the result it would deliver.
      res_vld <= (tv[MUL_LAT] && !bus.flush) ? lsb << ti[MUL_LAT] : '0;
      if (tv[MUL_LAT] && !bus.flush) res_p <= bus.mul_p;
    end
  assign bus.req_rdy = gnt;
  assign bus.mul_a = mul_a;
  assign bus.mul_b = mul_b;
  assign bus.mul_vld = tv[0];
  assign bus.res_p = res_p;
  assign bus.res_vld = res_vld;
  assign bus.busy = |tv | |res_vld;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed and random stimulus against a queue-based scoreboard of
// grants, products and result timing; a behavioural pipelined core drives mul_p.
module tb_booth_mul_arbiter;
  localparam int N = 4, DW = 16, L = 3;
  typedef struct {int idx; logic [2*DW-1:0] p; int due;} op_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_err = 0, mptr = 0, cyc = 0;
  logic iss_prev = 1'b0;
  logic [DW-1:0] ma = '0, mb = '0;
  logic [2*DW-1:0] last_p = '0;
  logic [2*DW-1:0] cp [L];
  op_t sb[$];
  int grants[$];
  always #5 clk = ~clk;
  booth_mul_arbiter_if #(.N_REQ(N), .DW(DW)) bus();
  booth_mul_arbiter #(.N_REQ(N), .DW(DW), .MUL_LAT(L)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk) begin
    cp[0] <= {{DW{bus.mul_a[DW-1]}}, bus.mul_a} * {{DW{bus.mul_b[DW-1]}}, bus.mul_b};
    for (int k = 1; k < L; k++) cp[k] <= cp[k-1];
  end
  assign bus.mul_p = cp[L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic step();
    int win;
    logic [N-1:0] er;
    logic signed [DW-1:0] a, b;
    logic popped;
    op_t o;
    @(negedge clk);
    er = '0;
    popped = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      er[sb[0].idx] = 1'b1;
      last_p = sb[0].p;
      void'(sb.pop_front());
      popped = 1'b1;
    end
    check("res_vld", bus.res_vld, er);
    check("res_p", bus.res_p, last_p);
    check("busy", bus.busy, popped || sb.size() > 0);
    check("mul_vld", bus.mul_vld, iss_prev);
    check("mul_a", bus.mul_a, ma);
    check("mul_b", bus.mul_b, mb);
    win = -1;
    if (!bus.flush)
      for (int k = 0; k < N; k++)
        if (win < 0 && bus.req_vld[(mptr + k) % N]) win = (mptr + k) % N;
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    check("req_rdy", bus.req_rdy, er);
    if (bus.flush) sb.delete();
    iss_prev = win >= 0;
    if (win >= 0) begin
      a = bus.req_a[win*DW +: DW];
      b = bus.req_b[win*DW +: DW];
      ma = a;
      mb = b;
      o.idx = win;
      o.p = int'(a) * int'(b);
      o.due = cyc + L + 2;
      sb.push_back(o);
      grants.push_back(win);
`ifdef MUL_ARB_LOCK_EN
      mptr = bus.req_lock[win] ? win : (win + 1) % N;
`else
      mptr = (win + 1) % N;
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_vld = '0;
    bus.flush = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_grants(input string tag, input int exp[6]);
    check({tag, "_n"}, grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check(tag, grants[i], exp[i]);
  endtask

  initial begin
    int exp3[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef MUL_ARB_LOCK_EN
    int exp6[6] = '{1, 1, 1, 1, 3, 0};
`else
    int exp6[6] = '{1, 3, 0, 1, 3, 0};
`endif
    bus.flush = 1'b0;
    bus.req_vld = '1;
    bus.req_a = '0;
    bus.req_b = '0;
`ifdef MUL_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    #12;
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_mul_vld", bus.mul_vld, 0);
    check("rst_mul_a", bus.mul_a, 0);
    check("rst_mul_b", bus.mul_b, 0);
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_res_p", bus.res_p, 0);
    check("rst_busy", bus.busy, 0);
    bus.req_vld = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single op, then signed op, then re-align pointer to 0
    set_op(0, 16'h7FFF, 16'h0002);
    bus.req_vld = 4'b0001;
    step();
    idle(L + 3);
    set_op(2, 16'hFFFD, 16'h0005);
    bus.req_vld = 4'b0100;
    step();
    idle(L + 3);
    check("signed_p", last_p, 32'hFFFFFFF1);
    set_op(3, 16'h8000, 16'h8000);
    bus.req_vld = 4'b1000;
    step();
    idle(L + 3);
    check("minmin_p", last_p, 32'h40000000);
    // full contention
    grants.delete();
    bus.req_vld = 4'b1111;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
      step();
    end
    idle(L + 3);
    check("grant3_n", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) check("grant3", grants[i], exp3[i]);
    // flush with three ops in flight
    for (int i = 0; i < 3; i++) begin
      bus.req_vld = '0;
      bus.req_vld[i] = 1'b1;
      set_op(i, DW'($urandom), DW'($urandom));
      step();
    end
    bus.req_vld = 4'b1111;
    bus.flush = 1'b1;
    step();
    idle(2);
    set_op(1, 16'h0123, 16'hFF00);
    bus.req_vld = 4'b0010;
    step();
    idle(L + 3);
    // async reset with two ops in flight
    bus.req_vld = 4'b0001;
    step();
    bus.req_vld = 4'b0010;
    step();
    bus.req_vld = '0;
    #2;
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_mul_vld", bus.mul_vld, 0);
    check("arst_res_vld", bus.res_vld, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_res_p", bus.res_p, 0);
    sb.delete();
    mptr = 0;
    iss_prev = 1'b0;
    ma = '0;
    mb = '0;
    last_p = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.req_vld = 4'b1111;
    set_op(0, 16'h0011, 16'h0022);
    step();
    idle(L + 3);
    // lock scenario starting with ptr=1
    grants.delete();
    for (int s = 0; s < 6; s++) begin
      bus.req_vld = {1'b1, 1'b0, s < 4, 1'b1};
`ifdef MUL_ARB_LOCK_EN
      bus.req_lock = {2'b00, s < 4, 1'b0};
`endif
      for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
      step();
    end
`ifdef MUL_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    idle(L + 3);
    check_grants("grant6", exp6);
    // random traffic
    for (int s = 0; s < 400; s++) begin
      bus.req_vld = N'($urandom);
      bus.flush = $urandom_range(0, 15) == 0;
`ifdef MUL_ARB_LOCK_EN
      bus.req_lock = N'($urandom);
`endif
      for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
      step();
    end
    idle(L + 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
